shift_register_seq: RTL and testbench
=====================================

# shift_register_seq

Parametrised multi-mode shift register executing queued shift/rotate commands one bit position per clock, with a valid/ready command handshake and a completion pulse. Successor to the team's fixed 8-bit clear/load/shift-by-one register. Adds arithmetic shift, rotates, multi-position shifts, serial in/out and busy/done status. Sits between a control FSM or CSR block and datapath consumers that need bit-serialised or shifted words.

## Interface
- WIDTH, 8, register width; legal range 2 and up.
- AMT_W, $clog2(WIDTH+1), width of the shift-amount field.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  block idle and able to accept a command.
- cmd_op  in  3  opcode (see package).
- cmd_amt  in  AMT_W  positions to shift/rotate.
- load_data  in  WIDTH  value for OP_LOAD.
- ser_in  in  1  fill bit for SRL/SLL, sampled on every step.
- q  out  WIDTH  register contents.
- ser_out  out  1  bit expelled by the most recent step.
- busy  out  1  multi-step operation in progress; equals !cmd_ready.
- done  out  1  one-cycle pulse marking command completion.

## Operation
- Opcodes: NOP=0, CLR=1, LOAD=2, SRL=3, SLL=4, SRA=5, ROR=6, ROL=7.
- A command is accepted on an edge where cmd_valid && cmd_ready. cmd_valid while busy is ignored and not queued.
- NOP: q unchanged. CLR: q <= 0. LOAD: q <= load_data. All three complete in one cycle.
- Shift/rotate ops: effective amount k = min(cmd_amt, WIDTH), latched at accept. Exactly one position is applied per cycle for k cycles.
  - SRL: q <= {ser_in, q[WIDTH-1:1]}; ser_out <= q[0].
  - SLL: q <= {q[WIDTH-2:0], ser_in}; ser_out <= q[WIDTH-1].
  - SRA: MSB is replicated; ser_out <= q[0].
  - ROR/ROL: circular; ser_out takes the bit that wraps.
- k = 0: q unchanged, completes in one cycle like NOP.
- ser_out changes only on shift/rotate steps. It holds its value through NOP/CLR/LOAD.
- FSM states:
  - IDLE: cmd_ready=1. Accepting a shift with k>1 enters SHIFT, performs step 1, and loads remaining = k-1. Any other accept performs the whole op and stays in IDLE.
  - SHIFT: performs one step per cycle and decrements remaining. The edge performing the final step returns to IDLE.
- Reset values: q=0, ser_out=0, done=0, cmd_ready=1, busy=0, state IDLE, remaining=0.
- Reset mid-operation aborts the command. No done pulse is issued and all reset values apply on the next cycle.

## Timing
- Accept edge at cycle T. For one-cycle ops and for k≤1, q holds the result at T+1 and done=1 at T+1.
- For k>1, q shows step i at T+i and busy=1 during T+1..T+k-1. The final value and done=1 both appear at T+k.
- cmd_ready is high in the done cycle, so a new command can be accepted on the edge ending that cycle. Back-to-back throughput is one command per max(k,1) cycles.
- done is registered and is never high for two consecutive cycles unless two commands complete back-to-back.
- No combinational path from inputs to outputs. cmd_ready and busy are decoded from the state register.

## Structure
- Package shift_register_seq_pkg holds:
  - the 3-bit opcode enum/localparams;
  - state encoding IDLE/SHIFT;
  - a helper function for AMT_W.
- Sub-module shift_register_step: combinational single-position step unit. Inputs q, op and ser_in; outputs next q and expelled bit. The top contains only the FSM, counter and registers.

## Test plan
- WIDTH=8. LOAD 0xA5 → q=0xA5 and done=1 at T+1, cmd_ready stays 1.
- After loading 0xA5, SRL amt 3 with ser_in=0:
  - busy=1 at T+1..T+2;
  - q=0x14, ser_out=1 and done=1 at T+3.
- After loading 0x90, SRA amt 2 → q=0xE4 at T+2.
- After loading 0x01, SLL amt 2 with ser_in=1 → q=0x07.
- After loading 0x3C:
  - ROL amt 4 → q=0xC3 at T+4;
  - then ROR amt 9, clamped to 8 → q=0xC3 unchanged, done at T+8;
  - SRL amt 0 → q unchanged, done at T+1.
- Start SRL amt 5 on 0xFF and hold cmd_valid high with LOAD 0x00 while busy → LOAD is ignored. A second run of the same command with rst asserted at T+2 → next cycle q=0, done=0, cmd_ready=1, ser_out=0.

Source files
------------

// File: rtl/shift_register_seq_pkg.sv
// Shared types for the multi-mode shift register:
// opcodes, FSM states and the amount-width helper.
package shift_register_seq_pkg;

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_CLR  = 3'd1,
    OP_LOAD = 3'd2,
    OP_SRL  = 3'd3,
    OP_SLL  = 3'd4,
    OP_SRA  = 3'd5,
    OP_ROR  = 3'd6,
    OP_ROL  = 3'd7
  } op_e;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_e;

  function automatic int amt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/shift_register_step.sv
// Combinational single-position shift/rotate unit.
// Non-shift opcodes pass the word through unchanged.
module shift_register_step
  import shift_register_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q_i,
  input  op_e              op_i,
  input  logic             ser_i,
  output logic [WIDTH-1:0] q_o,
  output logic             bit_o
);

  always_comb begin
    q_o   = q_i;
    bit_o = 1'b0;
    unique case (op_i)
      OP_SRL: begin
        q_o   = {ser_i, q_i[WIDTH-1:1]};
        bit_o = q_i[0];
      end
      OP_SLL: begin
        q_o   = {q_i[WIDTH-2:0], ser_i};
        bit_o = q_i[WIDTH-1];
      end
      OP_SRA: begin
        q_o   = {q_i[WIDTH-1], q_i[WIDTH-1:1]};
        bit_o = q_i[0];
      end
      OP_ROR: begin
        q_o   = {q_i[0], q_i[WIDTH-1:1]};
        bit_o = q_i[0];
      end
      OP_ROL: begin
        q_o   = {q_i[WIDTH-2:0], q_i[WIDTH-1]};
        bit_o = q_i[WIDTH-1];
      end
      OP_NOP, OP_CLR, OP_LOAD: begin
        q_o   = q_i;
        bit_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/shift_register_seq.sv
// Command-driven shift register: one position per clock,
// valid/ready intake, registered done pulse.
module shift_register_seq
  import shift_register_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AMT_W = amt_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [AMT_W-1:0] cmd_amt,
  input  logic [WIDTH-1:0] load_data,
  input  logic             ser_in,
  output logic [WIDTH-1:0] q,
  output logic             ser_out,
  output logic             busy,
  output logic             done
);

  localparam logic [AMT_W-1:0] KMAX = AMT_W'(WIDTH);

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [AMT_W-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             so_q, so_d;
  logic             done_q, done_d;

  op_e              cop;
  op_e              step_op;
  logic [AMT_W-1:0] k;
  logic [WIDTH-1:0] step_q;
  logic             step_bit;

  assign cop     = op_e'(cmd_op);
  assign k       = (cmd_amt > KMAX) ? KMAX : cmd_amt;
  assign step_op = (state_q == S_SHIFT) ? op_q : cop;

  shift_register_step #(.WIDTH(WIDTH)) u_step (
    .q_i   (r_q),
    .op_i  (step_op),
    .ser_i (ser_in),
    .q_o   (step_q),
    .bit_o (step_bit)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rem_d   = rem_q;
    r_d     = r_q;
    so_d    = so_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          unique case (cop)
            OP_NOP: done_d = 1'b1;
            OP_CLR: begin
              r_d    = '0;
              done_d = 1'b1;
            end
            OP_LOAD: begin
              r_d    = load_data;
              done_d = 1'b1;
            end
            OP_SRL, OP_SLL, OP_SRA, OP_ROR, OP_ROL: begin
              if (k == '0) begin
                done_d = 1'b1;
              end else begin
                r_d  = step_q;
                so_d = step_bit;
                if (k == AMT_W'(1)) begin
                  done_d = 1'b1;
                end else begin
                  state_d = S_SHIFT;
                  op_d    = cop;
                  rem_d   = k - AMT_W'(1);
                end
              end
            end
          endcase
        end
      end
      S_SHIFT: begin
        r_d   = step_q;
        so_d  = step_bit;
        rem_d = rem_q - AMT_W'(1);
        if (rem_q == AMT_W'(1)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= OP_NOP;
      rem_q   <= '0;
      r_q     <= '0;
      so_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rem_q   <= rem_d;
      r_q     <= r_d;
      so_q    <= so_d;
      done_q  <= done_d;
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q == S_SHIFT);
  assign q         = r_q;
  assign ser_out   = so_q;
  assign done      = done_q;

endmodule

// File: tb/tb_shift_register_seq.sv
// Directed plus random bench for shift_register_seq (WIDTH=8),
// checked against a closed-form shift/rotate model.
module tb_shift_register_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [3:0] cmd_amt;
  logic [7:0] load_data;
  logic       ser_in;
  logic [7:0] q;
  logic       ser_out;
  logic       busy;
  logic       done;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] q_m;
  logic       so_m;

  shift_register_seq #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_amt   (cmd_amt),
    .load_data (load_data),
    .ser_in    (ser_in),
    .q         (q),
    .ser_out   (ser_out),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Result of k shift/rotate positions applied at once: {ser_out, q}.
  function automatic logic [8:0] ref_k(input logic [7:0] v,
                                       input logic [2:0] op,
                                       input int k, input logic s);
    logic [15:0] w;
    logic [7:0]  fill;
    logic [7:0]  r;
    logic        b;
    w    = {8'h00, v};
    fill = s ? 8'((16'd1 << k) - 16'd1) : 8'h00;
    r    = v;
    b    = 1'b0;
    case (op)
      3'd3: begin r = 8'(w >> k) | 8'(fill << (8 - k)); b = v[k-1]; end
      3'd4: begin r = 8'(w << k) | fill;               b = v[8-k]; end
      3'd5: begin
        r = 8'($signed({{8{v[7]}}, v}) >>> k);
        b = v[k-1];
      end
      3'd6: begin r = 8'((w >> k) | (w << (8 - k)));   b = v[k-1]; end
      3'd7: begin r = 8'((w << k) | (w >> (8 - k)));   b = v[8-k]; end
      default: begin r = v; b = 1'b0; end
    endcase
    return {b, r};
  endfunction

  task automatic run_cmd(input logic [2:0] op, input int amt,
                         input logic [7:0] d, input logic s);
    int kk;
    int n;
    logic sh;
    logic [8:0] r;
    logic [7:0] eq;
    logic es;
    cmd_op    = op;
    cmd_amt   = 4'(amt);
    load_data = d;
    ser_in    = s;
    cmd_valid = 1'b1;
    check("ready_pre", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
    kk = (amt > 8) ? 8 : amt;
    sh = (op >= 3'd3);
    n  = (sh && kk > 1) ? kk : 1;
    eq = q_m;
    es = so_m;
    for (int i = 1; i <= n; i++) begin
      if (sh && kk > 0) begin
        r  = ref_k(q_m, op, i, s);
        eq = r[7:0];
        es = r[8];
      end else if (op == 3'd1) begin
        eq = 8'h00;
      end else if (op == 3'd2) begin
        eq = d;
      end
      check("q", 32'(q), 32'(eq));
      check("ser_out", 32'(ser_out), 32'(es));
      check("busy", 32'(busy), 32'(i < n));
      check("done", 32'(done), 32'(i == n));
      check("ready", 32'(cmd_ready), 32'(i == n));
      if (i < n) tick();
    end
    q_m  = eq;
    so_m = es;
  endtask

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
    cmd_amt   = 4'd0;
    load_data = 8'h00;
    ser_in    = 1'b0;
    q_m       = 8'h00;
    so_m      = 1'b0;
    tick();
    tick();
    check("rst_q", 32'(q), 32'd0);
    check("rst_ser", 32'(ser_out), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ready", 32'(cmd_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    tick();

    run_cmd(3'd2, 0, 8'hA5, 1'b0);
    run_cmd(3'd3, 3, 8'h00, 1'b0);
    check("srl3_q", 32'(q), 32'h14);
    check("srl3_so", 32'(ser_out), 32'd1);
    run_cmd(3'd2, 0, 8'h90, 1'b0);
    run_cmd(3'd5, 2, 8'h00, 1'b0);
    check("sra2_q", 32'(q), 32'hE4);
    run_cmd(3'd2, 0, 8'h01, 1'b0);
    run_cmd(3'd4, 2, 8'h00, 1'b1);
    check("sll2_q", 32'(q), 32'h07);
    run_cmd(3'd2, 0, 8'h3C, 1'b0);
    run_cmd(3'd7, 4, 8'h00, 1'b0);
    check("rol4_q", 32'(q), 32'hC3);
    run_cmd(3'd6, 9, 8'h00, 1'b1);
    check("ror9_q", 32'(q), 32'hC3);
    run_cmd(3'd3, 0, 8'h00, 1'b1);
    check("srl0_q", 32'(q), 32'hC3);
    run_cmd(3'd1, 0, 8'h00, 1'b0);
    run_cmd(3'd0, 0, 8'h00, 1'b0);

    for (int j = 0; j < 60; j++) begin
      run_cmd(3'($urandom_range(7)), int'($urandom_range(15)),
              8'($urandom), 1'($urandom));
    end

    // SRL 5 on 0xFF with a LOAD held valid during the busy window.
    run_cmd(3'd2, 0, 8'hFF, 1'b0);
    cmd_op    = 3'd3;
    cmd_amt   = 4'd5;
    ser_in    = 1'b0;
    cmd_valid = 1'b1;
    tick();
    cmd_op    = 3'd2;
    load_data = 8'h00;
    for (int i = 1; i <= 5; i++) begin
      logic [8:0] r;
      r = ref_k(8'hFF, 3'd3, i, 1'b0);
      check("ign_q", 32'(q), 32'(r[7:0]));
      check("ign_done", 32'(done), 32'(i == 5));
      if (i < 5) tick();
    end
    cmd_valid = 1'b0;
    check("ign_final", 32'(q), 32'h07);
    check("ign_so", 32'(ser_out), 32'd1);
    tick();
    check("ign_noload", 32'(q), 32'h07);

    q_m  = 8'h07;
    so_m = 1'b1;
    run_cmd(3'd2, 0, 8'hFF, 1'b0);
    cmd_op    = 3'd3;
    cmd_amt   = 4'd5;
    ser_in    = 1'b0;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    check("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    check("abort_q", 32'(q), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_ready", 32'(cmd_ready), 32'd1);
    check("abort_ser", 32'(ser_out), 32'd0);
    rst = 1'b0;
    tick();
    check("abort_nodone", 32'(done), 32'd0);
    check("abort_hold", 32'(q), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
